pdp8_tt_uart: RTL and testbench
===============================

Name: pdp8_tt_uart

Overview:
- Serial engine for the PDP-8 console teletype: 8N1 async transmitter and receiver, sitting directly below the console IOT device.
- Receives bytes from the console device over a req/ack handshake, shifts them out on tx_out, deserialises rx_in, and offers received bytes over a second req/ack handshake.
- Baud timing comes from the baud-rate generator as level toggles; everything else runs on clk.

Parameters:
- OVERSAMPLE, 16, rx ticks per bit; power of 2, ≥8.
- SYNC_STAGES, 2, flops in each input synchroniser (rx_in, tx_clk, rx_clk).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tx_clk  in  1  baud level from generator; each rising edge = one tx bit time.
- tx_req  in  1  console requests a byte load.
- tx_ack  out  1  byte latched; held until tx_req drops.
- tx_data  in  8  byte to send; sampled on the req/ack grant cycle.
- tx_empty  out  1  holding register empty and shifter idle.
- rx_clk  in  1  baud level; each rising edge = one rx sample (OVERSAMPLE per bit).
- rx_req  in  1  console requests the received byte.
- rx_ack  out  1  rx_data valid; held until rx_req drops.
- rx_data  out  8  last byte granted to the console; stable between grants.
- rx_empty  out  1  low while an unread byte is in the receive holding register.
- rx_in  in  1  serial input, idle high.
- tx_out  out  1  serial output, idle high.

Behaviour:
- Clocking and reset:
  - One clock, clk. reset is synchronous and active-high.
  - tx_clk, rx_clk and rx_in each pass through a SYNC_STAGES synchroniser. tx_clk and rx_clk are then rising-edge detected into one-cycle ticks tx_tick and rx_tick.
  - Reset values: tx_out=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0, both FSMs IDLE, holding registers empty.
  - Reset in mid-frame aborts the frame; tx_out returns to 1 on the next cycle.
- TX handshake:
  - Grant when tx_req=1, tx_ack=0 and the tx holding register is empty.
  - On grant: latch tx_data into the holding register, set tx_ack=1.
  - tx_ack clears the cycle after tx_req is seen low.
  - tx_req that stays high after ack causes no second load.
- TX FSM (IDLE, START, DATA, STOP), advancing only on tx_tick:
  - IDLE with holding full: move holding to the shifter, free holding, drive tx_out=0, go to START.
  - START → DATA: drive bit0.
  - DATA: shifts LSB first for 8 ticks (bit counter 0..7), then goes to STOP with tx_out=1.
  - STOP: after one tick returns to IDLE, or reloads straight into START if holding is full (back-to-back frames, no extra idle bit).
  - tx_empty = holding empty AND FSM IDLE, registered.
- RX FSM (IDLE, START, DATA, STOP), advancing on rx_tick with a sample counter mod OVERSAMPLE:
  - IDLE: a low sample starts the counter and moves to START.
  - START: at sample OVERSAMPLE/2 the line must still be 0, otherwise it is a false start and the FSM returns to IDLE. If valid, the counter is re-centred.
  - DATA: one sample every OVERSAMPLE ticks, 8 bits LSB first.
  - STOP: at mid-bit, 1 → write the shifter into the rx holding register and set rx_empty=0; 0 → framing error, byte discarded, rx_empty unchanged. Return to IDLE either way.
- RX handshake:
  - Grant when rx_req=1, rx_ack=0 and rx_empty=0: copy holding to rx_data, set rx_ack=1, set rx_empty=1.
  - rx_ack clears the cycle after rx_req is seen low.
  - Overrun: a new byte completing while the holding register is full overwrites it; rx_data is unaffected until the next grant.
  - New byte completing in the same cycle as a grant: the grant takes the old byte, the new byte lands in holding, and rx_empty stays 0.

Optional Feature:
- Macro PDP8_TT_LOOPBACK_EN.
- Defined: the receiver's synchroniser input is the internal transmit shift output instead of rx_in, and tx_out is forced to 1. Used for self-test without a terminal.
- Undefined: normal pins, no loopback logic.

Decomposition:
- Shared include pdp8_tt_defs.vh holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3);
  - frame constants (8 data bits, 1 stop bit).
- Sub-module pdp8_tt_uart_rx (synchroniser, oversample FSM, holding register) is natural; the transmitter stays inline.

Test Plan:
- Reset then idle 1000 cycles → tx_out=1, tx_empty=1, rx_empty=1, no acks.
- Full TX handshake with tx_data=8'h41 → tx_ack rises 1 cycle after req; tx_out frame is 0,1,0,0,0,0,0,1,0,1 per tx_tick; tx_empty returns to 1 after the stop bit.
- Two back-to-back loads 8'h55 then 8'hAA → second tx_ack waits until holding frees; contiguous frames with no idle bit between.
- Drive rx_in with 8'hC3 at 16x → rx_empty=0 after stop; rx_req gives rx_ack, rx_data=8'hC3, rx_empty=1.
- Glitch low for 4 rx_ticks, then a frame with stop bit 0 → no byte accepted, rx_empty stays 1.
- Receive 8'h31 and 8'h32 without reading, then grant → rx_data=8'h32 (overrun overwrite); with PDP8_TT_LOOPBACK_EN, sending 8'h7E yields rx_data=8'h7E and tx_out stays 1.

Source files
------------

// File: rtl/pdp8_tt_uart_pkg.sv
// Shared definitions for the PDP-8 console teletype serial engine:
// FSM state encoding and 8N1 frame constants.
package pdp8_tt_uart_pkg;

    // Both the transmitter and the receiver walk the same four frame phases.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tt_state_e;

    localparam int unsigned DataBits = 8;
    localparam int unsigned StopBits = 1;

    // Bit counter value of the final data bit.
    localparam logic [2:0] LastBit = 3'(DataBits - 1);

endpackage

// File: rtl/pdp8_tt_uart_rx.sv
// 8N1 oversampling receiver: input synchronisers, rx baud edge detect,
// start/data/stop FSM, holding register and console req/ack handshake.
module pdp8_tt_uart_rx
    import pdp8_tt_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_clk,
    input  logic       rx_serial,
    input  logic       rx_req,
    output logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_empty
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   rx_tick, rxs;

    tt_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      data_q, data_d;
    logic            empty_q, empty_d;
    logic            ack_q, ack_d;
    logic            rx_write, rx_grant;

    // Synchronise the baud level and serial line, then detect baud rising edges.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], rx_clk};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], rx_serial};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        rx_tick    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        rxs        = din_sync_q[SYNC_STAGES-1];
    end

    // Frame FSM: sample counter runs mod OVERSAMPLE, re-centred on the start bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_write = 1'b0;
        if (rx_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        cnt_d   = '0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfM1) begin
                        if (!rxs) begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = StData;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == FullM1) begin
                        cnt_d   = '0;
                        shift_d = {rxs, shift_q[7:1]};
                        if (bit_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == FullM1) begin
                        // A low stop bit is a framing error: the byte is dropped.
                        rx_write = rxs;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Console handshake; a completing byte wins the holding register over a grant.
    always_comb begin
        rx_grant = rx_req & ~ack_q & ~empty_q;
        ack_d    = ack_q;
        data_d   = data_q;
        hold_d   = hold_q;
        empty_d  = empty_q;
        if (rx_grant) begin
            ack_d   = 1'b1;
            data_d  = hold_q;
            empty_d = 1'b1;
        end else if (!rx_req) begin
            ack_d = 1'b0;
        end
        if (rx_write) begin
            hold_d  = shift_q;
            empty_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= '0;
            din_sync_q <= '1;
            clk_prev_q <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            data_q     <= '0;
            empty_q    <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            din_sync_q <= din_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            data_q     <= data_d;
            empty_q    <= empty_d;
            ack_q      <= ack_d;
        end
    end

    assign rx_ack   = ack_q;
    assign rx_data  = data_q;
    assign rx_empty = empty_q;

endmodule

// File: rtl/pdp8_tt_uart.sv
// PDP-8 console teletype serial engine: inline 8N1 transmitter plus the
// oversampling receiver sub-module. Define PDP8_TT_LOOPBACK_EN to feed the
// transmit shift output into the receiver and hold tx_out high (self-test).
module pdp8_tt_uart
    import pdp8_tt_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_clk,
    input  logic       tx_req,
    output logic       tx_ack,
    input  logic [7:0] tx_data,
    output logic       tx_empty,
    input  logic       rx_clk,
    input  logic       rx_req,
    output logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    input  logic       rx_in,
    output logic       tx_out
);

    logic [SYNC_STAGES-1:0] txc_sync_q, txc_sync_d;
    logic                   txc_prev_q, txc_prev_d;
    logic                   tx_tick, tx_grant;

    tt_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_full_q, tx_full_d;
    logic       tx_line_q, tx_line_d;
    logic       tx_ack_q, tx_ack_d;
    logic       tx_empty_q, tx_empty_d;
    logic       rx_serial;

    // Synchronise the tx baud level and turn its rising edges into ticks.
    always_comb begin
        txc_sync_d = {txc_sync_q[SYNC_STAGES-2:0], tx_clk};
        txc_prev_d = txc_sync_q[SYNC_STAGES-1];
        tx_tick    = txc_sync_q[SYNC_STAGES-1] & ~txc_prev_q;
    end

    // Load handshake plus frame FSM; the holding register is only freed on a tick.
    always_comb begin
        tx_grant   = tx_req & ~tx_ack_q & ~tx_full_q;
        tx_ack_d   = tx_ack_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        if (tx_grant) begin
            tx_ack_d  = 1'b1;
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end else if (!tx_req) begin
            tx_ack_d = 1'b0;
        end
        if (tx_tick) begin
            unique case (tx_state_q)
                StIdle, StStop: begin
                    // From STOP a full holding register reloads with no idle bit.
                    if (tx_full_q) begin
                        tx_shift_d = tx_hold_q;
                        tx_full_d  = 1'b0;
                        tx_line_d  = 1'b0;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end
                StStart: begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                end
                StData: begin
                    if (tx_bit_q == LastBit) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = StStop;
                    end else begin
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
                default: tx_state_d = StIdle;
            endcase
        end
        tx_empty_d = ~tx_full_d & (tx_state_d == StIdle);
    end

    // Transmitter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            txc_sync_q <= '0;
            txc_prev_q <= 1'b0;
            tx_state_q <= StIdle;
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_ack_q   <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            txc_sync_q <= txc_sync_d;
            txc_prev_q <= txc_prev_d;
            tx_state_q <= tx_state_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_full_q  <= tx_full_d;
            tx_line_q  <= tx_line_d;
            tx_ack_q   <= tx_ack_d;
            tx_empty_q <= tx_empty_d;
        end
    end

    assign tx_ack   = tx_ack_q;
    assign tx_empty = tx_empty_q;

`ifdef PDP8_TT_LOOPBACK_EN
    logic unused_rx_in;
    assign unused_rx_in = rx_in;
    assign rx_serial    = tx_line_q;
    assign tx_out       = 1'b1;
`else
    assign rx_serial = rx_in;
    assign tx_out    = tx_line_q;
`endif

    pdp8_tt_uart_rx #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx_clk    (rx_clk),
        .rx_serial (rx_serial),
        .rx_req    (rx_req),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty)
    );

endmodule

// File: tb/tb_pdp8_tt_uart.sv
// Scoreboard bench for pdp8_tt_uart: serial-line monitor for TX, req/ack
// monitor for RX, both popping expectations pushed by the stimulus.
module tb_pdp8_tt_uart;

    localparam int RxHalf = 2;               // clk cycles per rx_clk half period
    localparam int RxBit  = 2 * RxHalf * 16; // clk cycles per received bit
`ifdef PDP8_TT_LOOPBACK_EN
    localparam int TxHalf = RxBit / 2;       // loopback needs matching bit rates
`else
    localparam int TxHalf = 10;
`endif
    localparam int TxBit  = 2 * TxHalf;

    logic       clk = 1'b0, reset = 1'b1;
    logic       tx_clk = 1'b0, rx_clk = 1'b0;
    logic       tx_req = 1'b0, rx_req = 1'b0, rx_in = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ack, tx_empty, rx_ack, rx_empty, tx_out;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    // Reference model of the receive side: holding register and last grant.
    logic [7:0] model_hold = 8'h00;
    bit         model_full = 1'b0;
    logic [7:0] model_last = 8'h00;
    longint     last_start = 0;
    longint     last_gap   = 0;

    pdp8_tt_uart dut (
        .clk      (clk),
        .reset    (reset),
        .tx_clk   (tx_clk),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack),
        .tx_data  (tx_data),
        .tx_empty (tx_empty),
        .rx_clk   (rx_clk),
        .rx_req   (rx_req),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_in    (rx_in),
        .tx_out   (tx_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (TxHalf) @(negedge clk);
        tx_clk = ~tx_clk;
    end

    initial forever begin
        repeat (RxHalf) @(negedge clk);
        rx_clk = ~rx_clk;
    end

    function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // TX monitor: decode each frame on tx_out at mid-bit and score it.
    initial begin : tx_mon
        logic [7:0] b;
        logic       s0, s1;
        longint     t0;
        @(negedge reset);
        forever begin
            @(negedge tx_out);
            t0 = $time;
            last_gap = (t0 - last_start) / 10;
            last_start = t0;
            repeat (TxHalf) @(negedge clk);
            s0 = tx_out;
            for (int i = 0; i < 8; i++) begin
                repeat (TxBit) @(negedge clk);
                b[i] = tx_out;
            end
            repeat (TxBit) @(negedge clk);
            s1 = tx_out;
            check_eq("tx_start_bit", 32'(s0), 32'd0);
            check_eq("tx_stop_bit", 32'(s1), 32'd1);
            check_eq("tx_frame_expected", 32'(tx_exp.size() > 0), 32'd1);
            if (tx_exp.size() > 0) check_eq("tx_frame_byte", 32'(b), 32'(tx_exp.pop_front()));
        end
    end

    // RX monitor: every rising rx_ack must present the next expected byte.
    initial begin : rx_mon
        forever begin
            @(posedge rx_ack);
            @(negedge clk);
            check_eq("rx_grant_expected", 32'(rx_exp.size() > 0), 32'd1);
            if (rx_exp.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tx_send(input logic [7:0] b, input int hold, input bit on_line,
                           output int lat);
        int k;
        if (on_line) tx_exp.push_back(b);
        tx_data = b;
        tx_req  = 1'b1;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tx_ack && lat < 5000);
        check_eq("tx_ack_rise", 32'(tx_ack), 32'd1);
        tx_data = ~b; // must not matter: the byte was taken on the grant cycle
        repeat (hold) @(negedge clk);
        if (hold > 0) check_eq("tx_ack_held", 32'(tx_ack), 32'd1);
        tx_req = 1'b0;
        k = 0;
        while (tx_ack && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_ack_clear", 32'(tx_ack), 32'd0);
    endtask

    task automatic wait_tx_empty();
        int k = 0;
        while (!tx_empty && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_empty_after_frame", 32'(tx_empty), 32'd1);
        check_eq("tx_out_idle", 32'(tx_out), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        rx_in = 1'b0;
        repeat (RxBit) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (RxBit) @(negedge clk);
        end
        rx_in = stop;
        // A bad stop bit is released early so re-arming sees only a false start.
        repeat (stop ? RxBit : (RxBit * 3) / 4) @(negedge clk);
        rx_in = 1'b1;
        repeat (RxBit) @(negedge clk);
        if (stop) begin
            model_hold = b;
            model_full = 1'b1;
        end
    endtask

    task automatic rx_read();
        int k;
        rx_exp.push_back(model_hold);
        model_last = model_hold;
        model_full = 1'b0;
        rx_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_ack && k < 100);
        check_eq("rx_ack_rise", 32'(rx_ack), 32'd1);
        check_eq("rx_empty_after_grant", 32'(rx_empty), 32'd1);
        rx_req = 1'b0;
        k = 0;
        while (rx_ack && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("rx_ack_clear", 32'(rx_ack), 32'd0);
    endtask

    initial begin : stim
        int         lat1, lat2;
        logic [7:0] r;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_tx_out", 32'(tx_out), 32'd1);
        check_eq("reset_tx_empty", 32'(tx_empty), 32'd1);
        check_eq("reset_rx_empty", 32'(rx_empty), 32'd1);
        check_eq("reset_rx_data", 32'(rx_data), 32'd0);
        check_eq("reset_acks", 32'({tx_ack, rx_ack}), 32'd0);
        repeat (1000) @(negedge clk);
        check_eq("idle_tx_out", 32'(tx_out), 32'd1);
        check_eq("idle_tx_empty", 32'(tx_empty), 32'd1);
        check_eq("idle_rx_empty", 32'(rx_empty), 32'd1);
        check_eq("idle_acks", 32'({tx_ack, rx_ack}), 32'd0);

`ifdef PDP8_TT_LOOPBACK_EN
        @(negedge tx_clk);
        @(negedge clk);
        fork
            tx_send(8'h7E, 0, 1'b0, lat1);
            begin
                for (int i = 0; i < TxBit * 12; i++) begin
                    @(negedge clk);
                    if (tx_out !== 1'b1) check_eq("loopback_tx_out_high", 32'(tx_out), 32'd1);
                end
            end
        join
        model_hold = 8'h7E;
        model_full = 1'b1;
        check_eq("loopback_rx_empty", 32'(rx_empty), 32'd0);
        rx_read();
`else
        // Single frame 0x41, loaded from idle.
        @(negedge tx_clk);
        @(negedge clk);
        tx_send(8'h41, 0, 1'b1, lat1);
        check_eq("tx_ack_latency", 32'(lat1), 32'd1);
        check_eq("tx_empty_while_busy", 32'(tx_empty), 32'd0);
        wait_tx_empty();

        // Back-to-back: second load waits for the holding register, frames abut.
        @(negedge tx_clk);
        @(negedge clk);
        tx_send(8'h55, 0, 1'b1, lat1);
        tx_send(8'hAA, 0, 1'b1, lat2);
        check_eq("tx_b2b_first_latency", 32'(lat1), 32'd1);
        check_eq("tx_b2b_second_waits", 32'(lat2 > 1), 32'd1);
        wait_tx_empty();
        check_eq("tx_b2b_gap_cycles", 32'(last_gap), 32'(10 * TxBit));

        // tx_req held high long after ack must not reload the byte.
        tx_send(8'h96, 3 * TxBit, 1'b1, lat1);
        wait_tx_empty();
        repeat (12 * TxBit) @(negedge clk);
        check_eq("tx_no_second_load", 32'(tx_exp.size()), 32'd0);

        for (int n = 0; n < 4; n++) begin
            r = 8'($urandom);
            tx_send(r, 0, 1'b1, lat1);
            check_eq("tx_rand_latency", 32'(lat1), 32'd1);
            wait_tx_empty();
        end

        // Receive 0xC3 and read it.
        rx_frame(8'hC3, 1'b1);
        check_eq("rx_empty_after_byte", 32'(rx_empty), 32'(!model_full));
        rx_read();

        // Short glitch then a framing error: nothing accepted.
        rx_in = 1'b0;
        repeat (4 * 2 * RxHalf) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * RxBit) @(negedge clk);
        rx_frame(8'h5A, 1'b0);
        check_eq("rx_empty_after_errors", 32'(rx_empty), 32'(!model_full));

        // Overrun: the later byte overwrites, rx_data holds the last grant.
        rx_frame(8'h31, 1'b1);
        rx_frame(8'h32, 1'b1);
        check_eq("rx_data_stable", 32'(rx_data), 32'(model_last));
        check_eq("rx_empty_overrun", 32'(rx_empty), 32'(!model_full));
        rx_read();

        for (int n = 0; n < 4; n++) begin
            rx_frame(8'($urandom), 1'b1);
            check_eq("rx_rand_empty", 32'(rx_empty), 32'(!model_full));
            rx_read();
        end
`endif

        repeat (300) @(negedge clk);
        check_eq("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
        check_eq("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
